fetch_queue: RTL and testbench

- Instruction prefetch buffer between instruction memory and the IF/ID pipeline register.
- Each cycle it fetches one 16-bit instruction at its internal fetch PC and queues the instruction with its PC.
- It presents the oldest entry to the ID stage, holds it while ID stalls, and discards everything on a taken-branch redirect from the MEM stage.

---
 rtl/fetch_queue.sv | 130 +++++++++++++
 tb/tb_fetch_queue.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch buffer between instruction memory and
// the IF/ID pipeline register. Each cycle it fetches one instruction at the
// internal fetch PC and queues it with its PC. The oldest entry is presented
// to ID and held while ID stalls. A taken-branch redirect discards all
// entries and restarts fetching at the branch target.
//
// Ports:
//   clk         rising-edge clock
//   clear       asynchronous active-low reset
//   imem_addr   instruction memory address (always equals fetch_pc)
//   imem_data   instruction word, combinational read of imem_addr
//   stall       ID not accepting; head entry is held
//   redirect    taken branch: flush the queue and refetch
//   redirect_pc branch target, sampled while redirect=1
//   out_valid   head entry valid
//   out_inst    head instruction (0 when out_valid=0)
//   out_pc      PC of head instruction (0 when out_valid=0)
//   count       number of occupied entries
//   fetch_pc    next address to fetch
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 6,
    parameter int INST_W = 16
) (
    input  logic                     clk,
    input  logic                     clear,
    output logic [PC_W-1:0]          imem_addr,
    input  logic [INST_W-1:0]        imem_data,
    input  logic                     stall,
    input  logic                     redirect,
    input  logic [PC_W-1:0]          redirect_pc,
    output logic                     out_valid,
    output logic [INST_W-1:0]        out_inst,
    output logic [PC_W-1:0]          out_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic [PC_W-1:0]          fetch_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);
    localparam logic [AW-1:0]   PTR_ONE = AW'(1);
    localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);

    logic [INST_W-1:0] inst_mem_r [DEPTH];
    logic [PC_W-1:0]   pc_mem_r   [DEPTH];

    logic [AW-1:0]   rd_ptr_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [CW-1:0]   count_r;
    logic [PC_W-1:0] fetch_pc_r;

    logic            out_valid_s;
    logic            pop_s;
    logic            push_s;
    logic [CW-1:0]   count_nxt_s;

    // Handshake decode: a pop needs a valid head, a push needs room (or a
    // slot being freed by the same-cycle pop) and no flush in progress.
    always_comb begin
        out_valid_s = (count_r != {CW{1'b0}});
        pop_s       = out_valid_s & ~stall;
        push_s      = ~redirect & ((count_r < DEPTH_C) | pop_s);
    end

    // Occupancy update from the push/pop pair.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Control state: pointers, occupancy and fetch PC. Redirect overrides
    // everything, including a pop that would otherwise consume the head.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            rd_ptr_r   <= {AW{1'b0}};
            wr_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            fetch_pc_r <= {PC_W{1'b0}};
        end else if (redirect) begin
            rd_ptr_r   <= {AW{1'b0}};
            wr_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            fetch_pc_r <= redirect_pc;
        end else begin
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (push_s) begin
                wr_ptr_r   <= wr_ptr_r + PTR_ONE;
                fetch_pc_r <= fetch_pc_r + PC_ONE;
            end
            count_r <= count_nxt_s;
        end
    end

    // Entry storage; contents are don't-care after reset so no reset here.
    always_ff @(posedge clk) begin
        if (push_s) begin
            inst_mem_r[wr_ptr_r] <= imem_data;
            pc_mem_r[wr_ptr_r]   <= fetch_pc_r;
        end
    end

    // Head read from registered storage; no bypass from imem_data, so a
    // fetched word reaches the outputs one edge after it is fetched.
    always_comb begin
        if (out_valid_s) begin
            out_inst = inst_mem_r[rd_ptr_r];
            out_pc   = pc_mem_r[rd_ptr_r];
        end else begin
            out_inst = {INST_W{1'b0}};
            out_pc   = {PC_W{1'b0}};
        end
    end

    // Remaining outputs come straight from registers.
    always_comb begin
        out_valid = out_valid_s;
        count     = count_r;
        fetch_pc  = fetch_pc_r;
        imem_addr = fetch_pc_r;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue. Instruction memory holds 0x1000+k at
// address k. All observable outputs are packed into one vector and compared
// against hand-computed expectations after each clock edge.
module tb_fetch_queue;

    logic        clk;
    logic        clear;
    logic [5:0]  imem_addr;
    logic [15:0] imem_data;
    logic        stall;
    logic        redirect;
    logic [5:0]  redirect_pc;
    logic        out_valid;
    logic [15:0] out_inst;
    logic [5:0]  out_pc;
    logic [2:0]  count;
    logic [5:0]  fetch_pc;

    logic [15:0] imem [64];
    logic [37:0] obs;
    logic [37:0] exp_v;
    int          n_vec;
    int          n_err;

    fetch_queue #(.DEPTH(4), .PC_W(6), .INST_W(16)) dut (
        .clk         (clk),
        .clear       (clear),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .count       (count),
        .fetch_pc    (fetch_pc)
    );

    assign imem_data = imem[imem_addr];
    // {out_valid, out_inst, out_pc, count, fetch_pc, imem_addr}
    assign obs = {out_valid, out_inst, out_pc, count, fetch_pc, imem_addr};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        exp_v = {1'b0, 16'h0000, 6'd0, 3'd0, 6'd0, 6'd0};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL reset_async: got %h want %h", obs, exp_v);
        end
        @(negedge clk);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL reset_held: got %h want %h", obs, exp_v);
        end
        clear = 1'b1;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 4; i++) begin
            step();
            exp_v = {1'b1, 16'(32'h1000 + i), 6'(i), 3'd1, 6'(i + 1), 6'(i + 1)};
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL stream[%0d]: got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_stall_fill();
        int cnt;
        int fpc;
        stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            cnt = (i + 2 > 4) ? 4 : i + 2;
            fpc = (i < 3) ? 5 + i : 7;
            exp_v = {1'b1, 16'h1003, 6'd3, 3'(cnt), 6'(fpc), 6'(fpc)};
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL stall_fill[%0d]: got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_full_pop();
        stall = 1'b0;
        step();
        exp_v = {1'b1, 16'h1004, 6'd4, 3'd4, 6'd8, 6'd8};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL full_pulse: got %h want %h", obs, exp_v);
        end
        stall = 1'b1;
        step();
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL full_hold: got %h want %h", obs, exp_v);
        end
        stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            exp_v = {1'b1, 16'(32'h1005 + i), 6'(5 + i), 3'd4, 6'(9 + i), 6'(9 + i)};
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL drain[%0d]: got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_redirect();
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 6'h10;
        step();
        exp_v = {1'b0, 16'h0000, 6'd0, 3'd0, 6'h10, 6'h10};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL redirect_full: got %h want %h", obs, exp_v);
        end
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            exp_v = {1'b1, 16'h1010, 6'h10, 3'(i + 1), 6'(17 + i), 6'(17 + i)};
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL refill[%0d]: got %h want %h", i, obs, exp_v);
            end
        end
        redirect    = 1'b1;
        redirect_pc = 6'h20;
        step();
        exp_v = {1'b0, 16'h0000, 6'd0, 3'd0, 6'h20, 6'h20};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL redirect_stall: got %h want %h", obs, exp_v);
        end
        redirect = 1'b0;
        stall    = 1'b0;
        step();
        exp_v = {1'b1, 16'h1020, 6'h20, 3'd1, 6'h21, 6'h21};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL redirect_target: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_wrap();
        int p;
        redirect    = 1'b1;
        redirect_pc = 6'd5;
        step();
        exp_v = {1'b0, 16'h0000, 6'd0, 3'd0, 6'd5, 6'd5};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL redirect_first: got %h want %h", obs, exp_v);
        end
        redirect_pc = 6'd62;
        step();
        exp_v = {1'b0, 16'h0000, 6'd0, 3'd0, 6'd62, 6'd62};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL redirect_last_wins: got %h want %h", obs, exp_v);
        end
        redirect = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            p = (62 + i) % 64;
            exp_v = {1'b1, 16'(32'h1000 + p), 6'(p), 3'd1, 6'((p + 1) % 64), 6'((p + 1) % 64)};
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL wrap[%0d]: got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_async_clear();
        stall = 1'b1;
        step();
        exp_v = {1'b1, 16'h1001, 6'd1, 3'd2, 6'd3, 6'd3};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL pre_clear: got %h want %h", obs, exp_v);
        end
        #2;
        clear = 1'b0;
        #1;
        exp_v = {1'b0, 16'h0000, 6'd0, 3'd0, 6'd0, 6'd0};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL clear_immediate: got %h want %h", obs, exp_v);
        end
        @(negedge clk);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL clear_held: got %h want %h", obs, exp_v);
        end
        clear = 1'b1;
        stall = 1'b0;
        step();
        exp_v = {1'b1, 16'h1000, 6'd0, 3'd1, 6'd1, 6'd1};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL restart: got %h want %h", obs, exp_v);
        end
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        clear       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 6'd0;
        for (int k = 0; k < 64; k++) begin
            imem[k] = 16'(32'h1000 + k);
        end
        test_reset();
        test_stream();
        test_stall_fill();
        test_full_pop();
        test_redirect();
        test_wrap();
        test_async_clear();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
